// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer control sequencer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [6:0] MAX_COUNT = 7'd99;
    localparam logic [6:0] LOAD_UP   = 7'd90;
    localparam logic [6:0] LOAD_DOWN = 7'd10;

    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;

    // Preset value depends on the counting direction: near the top when
    // counting up, near the bottom when counting down.
    function automatic logic [6:0] load_value(input logic dir);
        return dir ? LOAD_UP : LOAD_DOWN;
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_tick_gen.sv
// Modulo-N counter with a registered one-cycle tick. The tick is high for the
// cycle in which the count sits at N-1, so downstream logic sees it as a clean
// registered strobe. N must be at least 2.
module tick_gen #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] PRE  = W'(N - 2);

    logic [W-1:0] count_reg;

    // Count while enabled, hold otherwise; clear restarts the phase at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            tick      <= 1'b0;
        end else if (clear) begin
            count_reg <= '0;
            tick      <= 1'b0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
            tick      <= (count_reg == PRE);
        end else begin
            tick      <= 1'b0;
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Control sequencer for the 0-99 up/down counter: turns button pulses into
// counter strobes, paces the count, runs the expiry buzzer and scans digits.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 2**24,
    parameter int SCAN_DIV    = 2**16,
    parameter int BUZZ_CYCLES = 2**20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic       load_p,
    input  logic       up_down,
    input  logic [6:0] count_val,
    output logic       cnt_en,
    output logic       cnt_dir,
    output logic       cnt_load,
    output logic [6:0] load_val,
    output logic       buzzer,
    output logic [3:0] anode,
    output logic       digit_sel,
    output logic [1:0] state
);

    localparam int BW = $clog2(BUZZ_CYCLES + 1);
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES);
    localparam logic [BW-1:0] BUZZ_ONE  = BW'(1);

    state_t          state_reg, state_next;
    logic            dir_reg;
    logic            cnt_load_reg, cnt_load_next;
    logic [6:0]      load_val_reg, load_val_next;
    logic            buzzer_reg, buzzer_next;
    logic [BW-1:0]   buzz_cnt_reg, buzz_cnt_next;
    logic            digit_sel_reg;
    logic [3:0]      anode_reg;
    logic            presc_clear;
    logic            presc_enable;
    logic            scan_tick;
    logic            expire_hit;

    // A stop pulse freezes the prescaler on the same edge it leaves RUN, so a
    // later resume continues exactly where counting left off.
    assign presc_enable = (state_reg == RUN) && !stop_p;

    // cnt_en is high only during the terminal-count cycle, which is where the
    // counter value (still showing the previous step) is tested for expiry.
    assign expire_hit = cnt_en &&
                        (dir_reg ? (count_val == MAX_COUNT) : (count_val == 7'd0));

    tick_gen #(.N(TICK_DIV)) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (presc_enable),
        .clear  (presc_clear),
        .tick   (cnt_en)
    );

    tick_gen #(.N(SCAN_DIV)) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (1'b1),
        .clear  (1'b0),
        .tick   (scan_tick)
    );

    // State, buzzer timer and registered command outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_load_reg <= 1'b0;
            load_val_reg <= 7'd0;
            buzzer_reg   <= 1'b0;
            buzz_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_load_reg <= cnt_load_next;
            load_val_reg <= load_val_next;
            buzzer_reg   <= buzzer_next;
            buzz_cnt_reg <= buzz_cnt_next;
        end
    end

    // Next-state logic; stop outranks load, which outranks start.
    always_comb begin
        state_next    = state_reg;
        cnt_load_next = 1'b0;
        load_val_next = 7'd0;
        buzz_cnt_next = buzz_cnt_reg;
        presc_clear   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (stop_p) begin
                    state_next = IDLE;
                end else if (load_p) begin
                    cnt_load_next = 1'b1;
                    load_val_next = load_value(dir_reg);
                end else if (start_p) begin
                    state_next  = RUN;
                    presc_clear = 1'b1;
                end
            end
            RUN: begin
                if (stop_p) begin
                    state_next = PAUSE;
                end else if (expire_hit) begin
                    state_next    = EXPIRED;
                    buzz_cnt_next = BUZZ_LOAD;
                end
            end
            PAUSE: begin
                if (stop_p) begin
                    state_next = IDLE;
                end else if (load_p) begin
                    cnt_load_next = 1'b1;
                    load_val_next = load_value(dir_reg);
                end else if (start_p) begin
                    state_next = RUN;
                end
            end
            EXPIRED: begin
                if (stop_p || (buzz_cnt_reg <= BUZZ_ONE)) begin
                    state_next    = IDLE;
                    buzz_cnt_next = '0;
                end else begin
                    buzz_cnt_next = buzz_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        buzzer_next = (state_next == EXPIRED);
    end

    // Direction follows the switch only while idle, so a run cannot flip mid-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            dir_reg <= up_down;
        end
    end

    // Free-running digit scan; anode pattern is registered alongside the select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel_reg <= 1'b0;
            anode_reg     <= AN_ONES;
        end else if (scan_tick) begin
            digit_sel_reg <= ~digit_sel_reg;
            anode_reg     <= digit_sel_reg ? AN_ONES : AN_TENS;
        end
    end

    assign cnt_dir   = dir_reg;
    assign cnt_load  = cnt_load_reg;
    assign load_val  = load_val_reg;
    assign buzzer    = buzzer_reg;
    assign digit_sel = digit_sel_reg;
    assign anode     = anode_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed vector table, multi-cycle corner
// sequences and randomized pulses against a cycle-level reference model.
module tb_countdown_timer_ctrl;

    localparam int TD = 4;
    localparam int SD = 2;
    localparam int BC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_p = 1'b0;
    logic       stop_p = 1'b0;
    logic       load_p = 1'b0;
    logic       up_down = 1'b0;
    logic [6:0] count_val = 7'd0;
    logic       cnt_en;
    logic       cnt_dir;
    logic       cnt_load;
    logic [6:0] load_val;
    logic       buzzer;
    logic [3:0] anode;
    logic       digit_sel;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    countdown_timer_ctrl #(
        .TICK_DIV    (TD),
        .SCAN_DIV    (SD),
        .BUZZ_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_p   (start_p),
        .stop_p    (stop_p),
        .load_p    (load_p),
        .up_down   (up_down),
        .count_val (count_val),
        .cnt_en    (cnt_en),
        .cnt_dir   (cnt_dir),
        .cnt_load  (cnt_load),
        .load_val  (load_val),
        .buzzer    (buzzer),
        .anode     (anode),
        .digit_sel (digit_sel),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 run, 2 pause, 3 expired. run_edges counts clock edges
    // spent counting since the last start from idle; a step happens every
    // TD of those. edges counts clocks since reset for the display scan.
    int m_mode, m_run, m_buzz, m_edges, m_lval;
    bit m_dir, m_en, m_load;

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_buzz = 0; m_edges = 0; m_lval = 0;
        m_dir = 0; m_en = 0; m_load = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit l, input bit ud,
                              input int cv);
        int  nmode;
        bit  counted;
        bit  hit;
        nmode   = m_mode;
        counted = 0;
        hit     = m_en && (m_dir ? (cv == 99) : (cv == 0));
        m_load  = 0;
        m_lval  = 0;
        case (m_mode)
            0: if (!p) begin
                   if (l) begin m_load = 1; m_lval = m_dir ? 90 : 10; end
                   else if (s) begin nmode = 1; m_run = 0; end
               end
            1: if (p) nmode = 2;
               else begin
                   counted = 1;
                   if (hit) begin nmode = 3; m_buzz = BC; end
               end
            2: if (p) nmode = 0;
               else if (l) begin m_load = 1; m_lval = m_dir ? 90 : 10; end
               else if (s) nmode = 1;
            default: if (p) nmode = 0;
               else begin
                   m_buzz = m_buzz - 1;
                   if (m_buzz == 0) nmode = 0;
               end
        endcase
        if (counted) m_run = m_run + 1;
        m_en = counted && ((m_run % TD) == TD - 1);
        if (m_mode == 0) m_dir = ud;
        m_mode  = nmode;
        m_edges = m_edges + 1;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample after the edge, compare with the model.
    task automatic cycle(input bit s, input bit p, input bit l, input bit ud, input logic [6:0] cv);
        logic [31:0] exp_v, act_v;
        bit          dsel;
        start_p = s; stop_p = p; load_p = l; up_down = ud; count_val = cv;
        @(posedge clk);
        #1;
        model_step(s, p, l, ud, int'(cv));
        dsel  = ((m_edges / SD) % 2) == 1;
        exp_v = {14'd0, 2'(m_mode), m_en, m_dir, m_load,
                 (m_load ? 7'(m_lval) : 7'd0), (m_mode == 3), dsel,
                 (dsel ? 4'b1101 : 4'b1110)};
        act_v = {14'd0, state, cnt_en, cnt_dir, cnt_load,
                 (m_load ? load_val : 7'd0), buzzer, digit_sel, anode};
        check($sformatf("model edge %0d", m_edges), act_v, exp_v);
        $display("[TB] edge %0d s=%0b p=%0b l=%0b ud=%0b cv=%0d -> st=%0d en=%0b ld=%0b lv=%0d bz=%0b an=%b",
                 m_edges, s, p, l, ud, cv, state, cnt_en, cnt_load, load_val, buzzer, anode);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " state"}, 32'(state), 32'd0);
        check({tag, " cnt_en"}, 32'(cnt_en), 32'd0);
        check({tag, " cnt_load"}, 32'(cnt_load), 32'd0);
        check({tag, " load_val"}, 32'(load_val), 32'd0);
        check({tag, " buzzer"}, 32'(buzzer), 32'd0);
        check({tag, " cnt_dir"}, 32'(cnt_dir), 32'd0);
        check({tag, " digit_sel"}, 32'(digit_sel), 32'd0);
        check({tag, " anode"}, 32'(anode), 32'he);
    endtask

    task automatic release_reset();
        start_p = 0; stop_p = 0; load_p = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Start a run with the given direction and wait for the terminal cycle
    // at the expiry value, then take the edge into EXPIRED.
    task automatic reach_expired(input bit ud);
        bit         found;
        logic [6:0] cv;
        cv = ud ? 7'd99 : 7'd0;
        found = 0;
        cycle(0, 0, 0, ud, cv);
        cycle(1, 0, 0, ud, cv);
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 0, ud, cv);
            if (cnt_en) found = 1;
        end
        check("expiry wait for cnt_en", 32'(found), 32'd1);
        cycle(0, 0, 0, ud, cv);
        check("expiry buzzer on", 32'(buzzer), 32'd1);
        check("expiry state", 32'(state), 32'd3);
    endtask

    typedef struct {
        bit         s, p, l, ud;
        logic [6:0] cv;
        logic [1:0] st;
        bit         en, dir, ld;
        logic [6:0] lv;
        bit         bz;
    } vec_t;

    vec_t vecs[25];

    initial begin
        //          s  p  l  ud  cv     st    en dir ld  lv     bz
        vecs[0]  = '{0, 0, 0, 0, 7'd0,  2'd0, 0, 0, 0, 7'd0,  0};
        vecs[1]  = '{0, 0, 1, 0, 7'd0,  2'd0, 0, 0, 1, 7'd10, 0};
        vecs[2]  = '{0, 0, 0, 1, 7'd0,  2'd0, 0, 1, 0, 7'd0,  0};
        vecs[3]  = '{0, 0, 1, 1, 7'd0,  2'd0, 0, 1, 1, 7'd90, 0};
        vecs[4]  = '{1, 0, 1, 1, 7'd0,  2'd0, 0, 1, 1, 7'd90, 0};
        vecs[5]  = '{0, 0, 0, 0, 7'd0,  2'd0, 0, 0, 0, 7'd0,  0};
        vecs[6]  = '{1, 0, 0, 0, 7'd0,  2'd1, 0, 0, 0, 7'd0,  0};
        vecs[7]  = '{0, 0, 0, 1, 7'd50, 2'd1, 0, 0, 0, 7'd0,  0};
        vecs[8]  = '{0, 0, 0, 1, 7'd50, 2'd1, 0, 0, 0, 7'd0,  0};
        vecs[9]  = '{0, 0, 0, 1, 7'd50, 2'd1, 1, 0, 0, 7'd0,  0};
        vecs[10] = '{0, 0, 0, 1, 7'd5,  2'd1, 0, 0, 0, 7'd0,  0};
        vecs[11] = '{0, 0, 0, 1, 7'd0,  2'd1, 0, 0, 0, 7'd0,  0};
        vecs[12] = '{0, 0, 0, 1, 7'd0,  2'd1, 0, 0, 0, 7'd0,  0};
        vecs[13] = '{0, 0, 0, 1, 7'd0,  2'd1, 1, 0, 0, 7'd0,  0};
        vecs[14] = '{0, 0, 0, 1, 7'd0,  2'd3, 0, 0, 0, 7'd0,  1};
        vecs[15] = '{0, 0, 1, 1, 7'd0,  2'd3, 0, 0, 0, 7'd0,  1};
        vecs[16] = '{1, 0, 0, 1, 7'd0,  2'd3, 0, 0, 0, 7'd0,  1};
        vecs[17] = '{0, 0, 0, 1, 7'd0,  2'd0, 0, 0, 0, 7'd0,  0};
        vecs[18] = '{1, 0, 0, 1, 7'd0,  2'd1, 0, 1, 0, 7'd0,  0};
        vecs[19] = '{0, 0, 1, 0, 7'd99, 2'd1, 0, 1, 0, 7'd0,  0};
        vecs[20] = '{0, 0, 0, 0, 7'd99, 2'd1, 0, 1, 0, 7'd0,  0};
        vecs[21] = '{0, 0, 0, 0, 7'd99, 2'd1, 1, 1, 0, 7'd0,  0};
        vecs[22] = '{0, 1, 0, 0, 7'd99, 2'd2, 0, 1, 0, 7'd0,  0};
        vecs[23] = '{0, 0, 1, 0, 7'd99, 2'd2, 0, 1, 1, 7'd90, 0};
        vecs[24] = '{0, 1, 0, 0, 7'd0,  2'd0, 0, 1, 0, 7'd0,  0};

        // Power-on reset.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        release_reset();

        // Directed vector table.
        for (int i = 0; i < 25; i++) begin
            cycle(vecs[i].s, vecs[i].p, vecs[i].l, vecs[i].ud, vecs[i].cv);
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d cnt_en", i), 32'(cnt_en), 32'(vecs[i].en));
            check($sformatf("vec%0d cnt_dir", i), 32'(cnt_dir), 32'(vecs[i].dir));
            check($sformatf("vec%0d cnt_load", i), 32'(cnt_load), 32'(vecs[i].ld));
            if (vecs[i].ld)
                check($sformatf("vec%0d load_val", i), 32'(load_val), 32'(vecs[i].lv));
            check($sformatf("vec%0d buzzer", i), 32'(buzzer), 32'(vecs[i].bz));
        end

        // Pause preserves prescaler phase.
        cycle(1, 0, 0, 1, 7'd50);
        cycle(0, 0, 0, 1, 7'd50);
        cycle(0, 0, 0, 1, 7'd50);
        cycle(0, 1, 0, 1, 7'd50);
        check("pause entered", 32'(state), 32'd2);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 1, 7'd50);
            check($sformatf("pause no step %0d", i), 32'(cnt_en), 32'd0);
        end
        cycle(1, 0, 0, 1, 7'd50);
        check("resume state", 32'(state), 32'd1);
        check("resume no early step", 32'(cnt_en), 32'd0);
        cycle(0, 0, 0, 1, 7'd50);
        check("resume phase step", 32'(cnt_en), 32'd1);
        cycle(0, 1, 0, 1, 7'd50);
        cycle(0, 1, 0, 1, 7'd50);
        check("pause stop to idle", 32'(state), 32'd0);

        // Stop silences the buzzer on the next cycle.
        reach_expired(1'b1);
        cycle(0, 1, 0, 1, 7'd0);
        check("stop silences buzzer", 32'(buzzer), 32'd0);
        check("stop expired to idle", 32'(state), 32'd0);

        // Asynchronous reset in the middle of EXPIRED.
        reach_expired(1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks("async");
        release_reset();

        // Randomized pulses against the model.
        for (int i = 0; i < 1500; i++) begin
            bit         s, p, l, ud;
            logic [6:0] cv;
            int         pick;
            s    = ($urandom_range(0, 5) == 0);
            p    = ($urandom_range(0, 9) == 0);
            l    = ($urandom_range(0, 7) == 0);
            ud   = ($urandom_range(0, 7) != 0) ? up_down : ~up_down;
            pick = int'($urandom_range(0, 3));
            cv   = (pick == 0) ? 7'd0 : (pick == 1) ? 7'd99 : 7'($urandom_range(0, 99));
            cycle(s, p, l, ud, cv);
        end
        start_p = 0; stop_p = 0; load_p = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
